// File: rtl/stream_demux_1ton_pkg.sv
// Shared definitions for the 1:N stream demultiplexer: FSM state encoding
// and the select range check.
package stream_demux_1ton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Out-of-range codes only exist when the channel count is not a power of 2.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned num_ch);
    return sel < num_ch;
  endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// One-entry valid/ready holding register. A load always wins over a take, so
// the entry can be refilled in the same cycle it drains.
module stream_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         take_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (take_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1:N packet demultiplexer. The channel is locked on the first beat
// of a packet; packets with an out-of-range select are dropped and flagged.
//
// Handshake: a beat moves on any interface at a rising edge where valid and
// ready are both high; valid is never withdrawn and payload never changes
// before that edge (except under rst).
module stream_demux_1ton
  import stream_demux_1ton_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_last,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     err_sel,
  output logic [1:0]               dbg_state_o
);

  localparam int HW = SEL_W + 1 + DATA_W;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_ch_q, cur_ch_d;
  logic              err_q, err_d;

  logic              hold_v;
  logic [HW-1:0]     hold_data;
  logic [SEL_W-1:0]  hold_ch;
  logic              hold_last;
  logic [DATA_W-1:0] hold_payload;

  logic              load;
  logic [SEL_W-1:0]  load_ch;
  logic              out_take;
  logic              accept;
  logic              start_ok;
  logic [NUM_CH-1:0] valid_fan;

  assign {hold_ch, hold_last, hold_payload} = hold_data;

  always_comb begin
    valid_fan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (hold_v && hold_ch == SEL_W'(k)) valid_fan[k] = 1'b1;
    end
  end

  // Only the selected channel's ready matters; the others are masked off by valid_fan.
  assign out_take = |(valid_fan & out_ready);
  assign in_ready = !rst && (state_q == ST_DROP || !hold_v || out_take);
  assign accept   = in_valid && in_ready;
  assign start_ok = sel_valid(32'(in_sel), 32'(NUM_CH));

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    err_d    = 1'b0;
    load     = 1'b0;
    load_ch  = cur_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (start_ok) begin
            load     = 1'b1;
            load_ch  = in_sel;
            cur_ch_d = in_sel;
            if (!in_last) state_d = ST_PKT;
          end else begin
            err_d = 1'b1;
            if (!in_last) state_d = ST_DROP;
          end
        end
      end
      ST_PKT: begin
        if (accept) begin
          load = 1'b1;
          if (in_last) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (accept && in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_ch_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      err_q    <= err_d;
    end
  end

  stream_hold_reg #(
    .W(HW)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .data_i ({load_ch, in_last, in_data}),
    .take_i (out_take),
    .valid_o(hold_v),
    .data_o (hold_data)
  );

  assign out_data    = {NUM_CH{hold_payload}};
  assign out_last    = {NUM_CH{hold_last}};
  assign out_valid   = valid_fan;
  assign err_sel     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: a 4-channel instance driven by directed and
// random packets against a packet-level queue model, plus a 3-channel instance.
module tb_stream_demux_1ton;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-channel DUT
  logic [7:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_last;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'hF;
  logic        err_sel;
  logic [1:0]  dbg_state;

  stream_demux_1ton #(.DATA_W(8), .NUM_CH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .err_sel(err_sel), .dbg_state_o(dbg_state)
  );

  // 3-channel DUT (sel code 3 is invalid)
  logic [7:0]  c_in_data = '0;
  logic [1:0]  c_in_sel = '0;
  logic        c_in_last = 1'b0;
  logic        c_in_valid = 1'b0;
  logic        c_in_ready;
  logic [23:0] c_out_data;
  logic [2:0]  c_out_last;
  logic [2:0]  c_out_valid;
  logic [2:0]  c_out_ready = 3'b111;
  logic        c_err_sel;
  logic [1:0]  c_dbg_state;

  stream_demux_1ton #(.DATA_W(8), .NUM_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_sel(c_in_sel), .in_last(c_in_last),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data), .out_last(c_out_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .err_sel(c_err_sel), .dbg_state_o(c_dbg_state)
  );

  // scoreboard: {ch, last, data} in global acceptance order of valid packets
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  int hs_cyc_q[$];
  int hs_ch_q[$];
  int valid_seen[4];
  int err_seen4 = 0;
  int stall_cnt = 0;
  int last_acc_cyc = 0;
  bit rand_rdy = 1'b0;

  logic [3:0]  prev_valid;
  logic [7:0]  prev_lane;
  logic        prev_stall = 1'b0;
  logic [7:0]  lane;
  logic [10:0] e_beat;
  logic [10:0] g_beat;

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 4'($urandom_range(0, 15));
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      lane = '0;
      for (int k = 0; k < 4; k++) if (out_valid[k]) lane = out_data[k*8 +: 8];
      checks++;
      if ($countones(out_valid) > 1) begin
        errors++;
        $display("FAIL onehot: out_valid=%b, required at most one bit", out_valid);
      end
      if (err_sel) err_seen4++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== prev_valid || lane !== prev_lane) begin
          errors++;
          $display("FAIL stable: valid=%b data=%h, required valid=%b data=%h", out_valid, lane, prev_valid, prev_lane);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k]) begin
          valid_seen[k]++;
          if (out_ready[k]) begin
            hs_cyc_q.push_back(cyc);
            hs_ch_q.push_back(k);
            g_beat = {2'(k), out_last[k], out_data[k*8 +: 8]};
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_beat: got ch/last/data=%h, required no output", g_beat);
            end else begin
              e_beat = exp_q.pop_front();
              if (g_beat !== e_beat) begin
                errors++;
                $display("FAIL beat: got ch/last/data=%h, required %h", g_beat, e_beat);
              end
            end
          end
        end
      end
      prev_valid = out_valid;
      prev_lane  = lane;
      prev_stall = (out_valid != 4'b0) && ((out_valid & out_ready) == 4'b0);
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic send_beat(input logic [7:0] d, input logic [1:0] s, input logic l,
                           input logic [1:0] exp_ch, input bit exp_ok);
    int n = 0;
    bit done = 1'b0;
    in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1'b1;
        last_acc_cyc = cyc;
        if (exp_ok) exp_q.push_back({exp_ch, l, d});
      end else begin
        stall_cnt++;
        n++;
        if (n >= 200) begin
          checks++; errors++; done = 1'b1;
          $display("FAIL accept_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  // model: the whole packet goes to the channel named on its first beat
  task automatic send_pkt(input logic [1:0] sel, input int len, input logic [7:0] base,
                          input bit chg_sel, output int first_acc);
    first_acc = 0;
    for (int i = 0; i < len; i++) begin
      send_beat(base + 8'(i), (i > 0 && chg_sel) ? 2'd0 : sel, (i == len - 1), sel, 1'b1);
      if (i == 0) first_acc = last_acc_cyc;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data = 8'($urandom);
    in_sel = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; c_in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (out_valid !== 4'b0)   begin errors++; $display("FAIL rst_valid: got %b required 0000", out_valid); end
    if (out_data !== 32'b0)   begin errors++; $display("FAIL rst_data: got %h required 0", out_data); end
    if (out_last !== 4'b0)    begin errors++; $display("FAIL rst_last: got %b required 0000", out_last); end
    if (err_sel !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b required 0", err_sel); end
    if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    if (dbg_state !== 2'd0)   begin errors++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
    if (c_out_valid !== 3'b0) begin errors++; $display("FAIL rst_valid3: got %b required 000", c_out_valid); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; c_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int fa;
    hs_cyc_q.delete(); hs_ch_q.delete();
    send_pkt(2'd2, 3, 8'hA1, 1'b0, fa);
    drain();
    checks++;
    if (hs_cyc_q.size() != 3) begin
      errors++; $display("FAIL basic_count: got %0d beats required 3", hs_cyc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (hs_ch_q[i] != 2 || hs_cyc_q[i] != fa + 1 + i) begin
          errors++;
          $display("FAIL basic_timing: beat %0d ch=%0d cyc=%0d required ch=2 cyc=%0d", i, hs_ch_q[i], hs_cyc_q[i], fa + 1 + i);
        end
      end
    end
  endtask

  task automatic test_sel_change();
    int fa;
    int v0 = valid_seen[0];
    hs_cyc_q.delete(); hs_ch_q.delete();
    send_pkt(2'd2, 3, 8'($urandom), 1'b1, fa);
    drain();
    checks += 2;
    if (valid_seen[0] != v0) begin errors++; $display("FAIL sel_change_ch0: got %0d valid cycles required 0", valid_seen[0] - v0); end
    if (hs_cyc_q.size() != 3) begin errors++; $display("FAIL sel_change_count: got %0d required 3", hs_cyc_q.size()); end
  endtask

  task automatic test_stall();
    int fa;
    logic [7:0] base = 8'($urandom);
    out_ready = 4'b1101;
    fork
      send_pkt(2'd1, 4, base, 1'b0, fa);
      begin
        @(negedge clk);
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b required 0", in_ready); end
        if (out_valid !== 4'b0010 || out_data[15:8] !== base) begin
          errors++; $display("FAIL stall_hold: valid=%b data=%h required 0010 %h", out_valid, out_data[15:8], base);
        end
        repeat (2) begin
          @(negedge clk);
          checks++;
          if (out_data[15:8] !== base) begin errors++; $display("FAIL stall_data: got %h required %h", out_data[15:8], base); end
        end
        @(posedge clk); #1;
        out_ready = 4'hF;
      end
    join
    drain();
  endtask

  task automatic test_back_to_back();
    int fa = 0;
    int st0 = stall_cnt;
    hs_cyc_q.delete(); hs_ch_q.delete();
    for (int s = 0; s < 4; s++) begin
      send_beat(8'h10 + 8'(s), 2'(s), 1'b1, 2'(s), 1'b1);
      if (s == 0) fa = last_acc_cyc;
    end
    drain();
    checks += 2;
    if (stall_cnt != st0) begin errors++; $display("FAIL b2b_in_ready: got %0d stall cycles required 0", stall_cnt - st0); end
    if (hs_cyc_q.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d required 4", hs_cyc_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hs_ch_q[i] != i || hs_cyc_q[i] != fa + 1 + i) begin
          errors++;
          $display("FAIL b2b_order: beat %0d ch=%0d cyc=%0d required ch=%0d cyc=%0d", i, hs_ch_q[i], hs_cyc_q[i], i, fa + 1 + i);
        end
      end
    end
  endtask

  task automatic test_invalid_sel();
    logic       t_v[7]   = '{1, 1, 1, 1, 0, 0, 0};
    logic [1:0] t_s[7]   = '{3, 3, 1, 1, 0, 0, 0};
    logic       t_l[7]   = '{0, 1, 0, 1, 0, 0, 0};
    logic [2:0] e_val[7] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000};
    logic       e_lst[7] = '{0, 0, 0, 0, 1, 0, 0};
    logic [7:0] d[4];
    int pulses = 0;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) begin
      c_in_valid = t_v[i]; c_in_sel = t_s[i]; c_in_last = t_l[i];
      c_in_data = (i < 4) ? d[i] : 8'h00;
      @(negedge clk);
      if (c_err_sel) pulses++;
      checks += 2;
      if (c_in_ready !== 1'b1) begin errors++; $display("FAIL inv_in_ready: cycle %0d got %b required 1", i, c_in_ready); end
      if (c_out_valid !== e_val[i]) begin errors++; $display("FAIL inv_valid: cycle %0d got %b required %b", i, c_out_valid, e_val[i]); end
      if (e_val[i][1]) begin
        checks++;
        if (c_out_data[15:8] !== d[i - 1] || c_out_last[1] !== e_lst[i]) begin
          errors++;
          $display("FAIL inv_data: cycle %0d got %h/%b required %h/%b", i, c_out_data[15:8], c_out_last[1], d[i - 1], e_lst[i]);
        end
      end
      if (i == 1) begin
        checks++;
        if (c_err_sel !== 1'b1) begin errors++; $display("FAIL inv_err_pulse: got %b required 1", c_err_sel); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL inv_err_count: got %0d pulses required 1", pulses); end
  endtask

  task automatic test_reset_mid();
    int fa;
    logic [7:0] d0 = 8'($urandom);
    send_beat(d0, 2'd2, 1'b0, 2'd2, 1'b1);
    rst = 1'b1; in_valid = 1'b1; in_data = d0 + 8'd1; in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks += 3;
    if (out_valid !== 4'b0) begin errors++; $display("FAIL rstmid_valid: got %b required 0000", out_valid); end
    if (err_sel !== 1'b0)   begin errors++; $display("FAIL rstmid_err: got %b required 0", err_sel); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d required 0", dbg_state); end
    @(posedge clk); #1;
    hs_cyc_q.delete(); hs_ch_q.delete();
    send_pkt(2'd0, 2, 8'($urandom), 1'b0, fa);
    drain();
    checks++;
    if (hs_ch_q.size() != 2) begin errors++; $display("FAIL rstmid_after: got %0d beats required 2", hs_ch_q.size()); end
  endtask

  task automatic test_random();
    int fa;
    rand_rdy = 1'b1;
    for (int p = 0; p < 25; p++) begin
      send_pkt(2'($urandom_range(0, 3)), $urandom_range(1, 4), 8'($urandom), 1'($urandom), fa);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    idle();
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 4'hF;
    drain();
    checks++;
    if (err_seen4 != 0) begin errors++; $display("FAIL err_4ch: got %0d pulses required 0", err_seen4); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) valid_seen[k] = 0;
    test_reset();
    test_basic();
    test_sel_change();
    test_stall();
    test_back_to_back();
    test_invalid_sel();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
